// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS2 scan-code receive path.
package ps2_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_PARITY,
      S_STOP,
      S_DELIVER
   } ps2_state_e;

   localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
   localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
   // start + 8 data + parity + stop
   localparam int         PS2_FRAME_BITS   = 11;
   localparam int         PS2_DATA_BITS    = PS2_FRAME_BITS - 3;

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS2 clock and data lines into the Clock_50 domain and
// flags the cycle on which the synchronised PS2 clock has just fallen.
module ps2_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic Clock_50,
   input  logic Reset,
   input  logic PS2_clock,
   input  logic PS2_data,
   output logic sync_data,
   output logic clk_fall
);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;

   // Synchroniser chains plus one history flop for falling-edge detection.
   // Reset to the idle-high bus level so leaving reset never looks like an edge.
   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make each flop take the previous
         // stage's old value, which is what builds a real multi-stage chain.
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_clock};
         data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign sync_data = data_sync[SYNC_STAGES-1];
   assign clk_fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS2 scan-code receiver: deserialises device frames, folds the F0 (break) and
// E0 (extended) prefixes into flags and hands one code per key event to the
// LCD-side logic as a one-cycle ready strobe.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity;
// without it the parity bit is ignored and only stop bit / timeout are errors.
module ps2_scan_receiver
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       Clock_50,
   input  logic       Reset,
   input  logic       PS2_clock,
   input  logic       PS2_data,
   output logic [7:0] PS2_code,
   output logic       PS2_code_ready,
   output logic       PS2_make_code,
   output logic       PS2_extended,
   output logic       PS2_frame_error
);

   localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]       LAST_BIT = 3'(PS2_DATA_BITS - 1);

   ps2_state_e       state;
   ps2_state_e       next_state;
   logic             sync_data;
   logic             clk_fall;
   logic [7:0]       shift_reg;
   logic [2:0]       bit_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             break_pending;
   logic             ext_pending;
   logic             shift_en;
   logic             start_frame;
   logic             frame_err_set;
   logic             tmo_hit;
   logic             parity_ok;

   ps2_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .Clock_50  (Clock_50),
      .Reset     (Reset),
      .PS2_clock (PS2_clock),
      .PS2_data  (PS2_data),
      .sync_data (sync_data),
      .clk_fall  (clk_fall)
   );

`ifdef PS2_PARITY_CHECK_EN
   logic parity_bit;

   // Parity bit is captured only when the check is built in.
   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset)
         parity_bit <= 1'b0;
      else if (state == S_PARITY && clk_fall)
         parity_bit <= sync_data;
   end

   assign parity_ok = ^{shift_reg, parity_bit};
`else
   assign parity_ok = 1'b1;
`endif

   // FSM state register.
   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   // Next-state and control decode; a mid-frame timeout overrides everything.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case leaves one unassigned, which would infer a latch.
      next_state    = state;
      shift_en      = 1'b0;
      start_frame   = 1'b0;
      frame_err_set = 1'b0;
      tmo_hit       = (state != S_IDLE) && !clk_fall && (tmo_cnt == TMO_LAST);
      case (state)
         S_IDLE: begin
            if (clk_fall && !sync_data) begin
               start_frame = 1'b1;
               next_state  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (clk_fall) begin
               shift_en = 1'b1;
               if (bit_cnt == LAST_BIT)
                  next_state = S_PARITY;
            end
         end
         S_PARITY: begin
            if (clk_fall)
               next_state = S_STOP;
         end
         S_STOP: begin
            if (clk_fall) begin
               if (sync_data && parity_ok) begin
                  next_state = S_DELIVER;
               end else begin
                  frame_err_set = 1'b1;
                  next_state    = S_IDLE;
               end
            end
         end
         S_DELIVER: next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
      if (tmo_hit) begin
         frame_err_set = 1'b1;
         next_state    = S_IDLE;
      end
   end

   // Data bits land LSB first at the position given by the bit counter.
   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         shift_reg <= 8'h00;
         bit_cnt   <= 3'd0;
      end else if (start_frame) begin
         bit_cnt <= 3'd0;
      end else if (shift_en) begin
         shift_reg[bit_cnt] <= sync_data;
         bit_cnt            <= bit_cnt + 3'd1;
      end
   end

   // Gap timer between PS2 clock edges; saturates rather than wrapping.
   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset)
         tmo_cnt <= '0;
      else if (clk_fall || state == S_IDLE)
         tmo_cnt <= '0;
      else if (tmo_cnt != TMO_LAST)
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   // Prefix folding and registered delivery; pendings survive bad frames.
   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         PS2_code        <= 8'h00;
         PS2_code_ready  <= 1'b0;
         PS2_make_code   <= 1'b0;
         PS2_extended    <= 1'b0;
         PS2_frame_error <= 1'b0;
         break_pending   <= 1'b0;
         ext_pending     <= 1'b0;
      end else begin
         PS2_code_ready  <= 1'b0;
         PS2_frame_error <= frame_err_set;
         if (state == S_DELIVER) begin
            case (shift_reg)
               PS2_BREAK_PREFIX: break_pending <= 1'b1;
               PS2_EXT_PREFIX:   ext_pending   <= 1'b1;
               default: begin
                  PS2_code       <= shift_reg;
                  PS2_make_code  <= ~break_pending;
                  PS2_extended   <= ext_pending;
                  PS2_code_ready <= 1'b1;
                  break_pending  <= 1'b0;
                  ext_pending    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver. PS2 bit timing is scaled down
// (a few dozen Clock_50 cycles per half bit) with a matching short timeout.
module tb_ps2_scan_receiver;

   localparam int SYNC = 2;
   localparam int TMO  = 200;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif

   typedef struct packed {
      logic       ext;
      logic       make;
      logic [7:0] code;
   } ev_t;

   logic       Clock_50 = 1'b0;
   logic       Reset    = 1'b1;
   logic       PS2_clock = 1'b1;
   logic       PS2_data  = 1'b1;
   logic [7:0] PS2_code;
   logic       PS2_code_ready;
   logic       PS2_make_code;
   logic       PS2_extended;
   logic       PS2_frame_error;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int unsigned ready_cyc = 0;
   int unsigned stop_cyc = 0;
   ev_t         got_q[$];
   ev_t         exp_q[$];
   int          got_err = 0;
   int          exp_err = 0;
   bit          model_brk = 1'b0;
   bit          model_ext = 1'b0;

   ps2_scan_receiver #(
      .SYNC_STAGES    (SYNC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .Clock_50        (Clock_50),
      .Reset           (Reset),
      .PS2_clock       (PS2_clock),
      .PS2_data        (PS2_data),
      .PS2_code        (PS2_code),
      .PS2_code_ready  (PS2_code_ready),
      .PS2_make_code   (PS2_make_code),
      .PS2_extended    (PS2_extended),
      .PS2_frame_error (PS2_frame_error)
   );

   initial forever #10 Clock_50 = ~Clock_50;

   always @(posedge Clock_50) cyc <= cyc + 1;

   // Monitor: record every ready strobe and frame-error strobe.
   initial forever begin
      @(negedge Clock_50);
      if (PS2_code_ready === 1'b1) begin
         got_q.push_back(ev_t'{PS2_extended, PS2_make_code, PS2_code});
         ready_cyc = cyc;
      end
      if (PS2_frame_error === 1'b1) got_err++;
   end

   // Reference model: one key event per non-prefix good frame.
   function automatic void model_frame(input logic [7:0] b, input bit good);
      if (!good)
         exp_err++;
      else if (b == 8'hF0)
         model_brk = 1'b1;
      else if (b == 8'hE0)
         model_ext = 1'b1;
      else begin
         exp_q.push_back(ev_t'{model_ext, !model_brk, b});
         model_brk = 1'b0;
         model_ext = 1'b0;
      end
   endfunction

   task automatic clear_log();
      @(negedge Clock_50);
      got_q.delete();
      exp_q.delete();
      got_err = 0;
      exp_err = 0;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_bad);
      int         half;
      logic [10:0] bits;
      half = $urandom_range(30, 50);
      bits = {~stop_bad, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         @(negedge Clock_50);
         PS2_data = bits[i];
         repeat (half) @(negedge Clock_50);
         PS2_clock = 1'b0;
         if (i == 10) stop_cyc = cyc;
         repeat (half) @(negedge Clock_50);
         PS2_clock = 1'b1;
      end
      repeat (half) @(negedge Clock_50);
      PS2_data = 1'b1;
      model_frame(b, !stop_bad && !(PAR_CHK && par_flip));
   endtask

   // Start bit plus nbits data bits, then the clock is left idle high.
   task automatic send_partial(input logic [7:0] b, input int nbits);
      logic [8:0] bits;
      bits = {b, 1'b0};
      for (int i = 0; i <= nbits; i++) begin
         @(negedge Clock_50);
         PS2_data = bits[i];
         repeat (40) @(negedge Clock_50);
         PS2_clock = 1'b0;
         repeat (40) @(negedge Clock_50);
         PS2_clock = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge Clock_50);
      checks++;
      if ({PS2_code, PS2_code_ready, PS2_make_code, PS2_extended, PS2_frame_error} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=000",
                  {PS2_code, PS2_code_ready, PS2_make_code, PS2_extended, PS2_frame_error});
      end
      Reset = 1'b0;
      repeat (5) @(negedge Clock_50);
      checks++;
      if (got_err != 0 || got_q.size() != 0) begin
         errors++;
         $display("FAIL reset_release events=%0d errs=%0d exp=0/0", got_q.size(), got_err);
      end
   endtask

   task automatic test_single_frame();
      clear_log();
      send_frame(8'h1C, 1'b0, 1'b0);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL single_event got=%h exp=%h", got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (int'(ready_cyc - stop_cyc) != SYNC + 2) begin
         errors++;
         $display("FAIL single_latency got=%0d exp=%0d", int'(ready_cyc - stop_cyc), SYNC + 2);
      end
      checks++;
      if (PS2_code !== 8'h1C || PS2_code_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_hold code=%h ready=%b exp=1c/0", PS2_code, PS2_code_ready);
      end
   endtask

   task automatic test_break();
      clear_log();
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL break_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL break_event%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_extended();
      clear_log();
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL ext_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL ext_event%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_frame_errors();
      clear_log();
      send_frame(8'h1C, 1'b1, 1'b0);   // wrong parity
      send_frame(8'hF0, 1'b0, 1'b0);   // break prefix survives the next bad frame
      send_frame(8'h33, 1'b0, 1'b1);   // bad stop bit
      send_frame(8'h1C, 1'b0, 1'b0);
      checks++;
      if (got_err != exp_err) begin
         errors++;
         $display("FAIL ferr_count got=%0d exp=%0d", got_err, exp_err);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL ferr_events got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL ferr_event%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_timeout();
      clear_log();
      send_partial(8'h5A, 4);
      repeat (TMO + 100) @(negedge Clock_50);
      exp_err++;
      checks++;
      if (got_err != exp_err) begin
         errors++;
         $display("FAIL timeout_err got=%0d exp=%0d", got_err, exp_err);
      end
      send_frame(8'h29, 1'b0, 1'b0);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL timeout_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL timeout_event got=%h exp=%h", got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_log();
      send_frame(8'hF0, 1'b0, 1'b0);
      send_partial(8'hA5, 5);
      Reset = 1'b1;
      model_brk = 1'b0;
      model_ext = 1'b0;
      repeat (3) @(negedge Clock_50);
      checks++;
      if ({PS2_code, PS2_code_ready, PS2_make_code, PS2_extended, PS2_frame_error} !== 12'h000) begin
         errors++;
         $display("FAIL midreset_outputs got=%h exp=000",
                  {PS2_code, PS2_code_ready, PS2_make_code, PS2_extended, PS2_frame_error});
      end
      Reset = 1'b0;
      repeat (TMO + 20) @(negedge Clock_50);
      send_frame(8'h16, 1'b0, 1'b0);
      checks++;
      if (got_err != exp_err) begin
         errors++;
         $display("FAIL midreset_err got=%0d exp=%0d", got_err, exp_err);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL midreset_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL midreset_event got=%h exp=%h", got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      int         sel;
      clear_log();
      for (int n = 0; n < 24; n++) begin
         sel = $urandom_range(0, 9);
         b   = (sel == 0) ? 8'hF0 : (sel == 1) ? 8'hE0 : 8'($urandom);
         send_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      end
      checks++;
      if (got_err != exp_err) begin
         errors++;
         $display("FAIL random_err got=%0d exp=%0d", got_err, exp_err);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL random_event%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_break();
      test_extended();
      test_frame_errors();
      test_timeout();
      test_reset_mid_frame();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
